// File: rtl/rpn_lan_tx_arbiter.sv
// Packet-locked round-robin AXI-Stream arbiter feeding the Network Bridge LAN ingress through a one-entry output stage.
// Define RPN_LAN_ARB_ACK_PRIORITY_EN to give requester 0 (ACK path) strict priority at arbitration.
module rpn_lan_tx_arbiter #(
  parameter int unsigned NUM_REQ              = 3,
  parameter int unsigned AXIS_DATA_WIDTH      = 512,
  parameter int unsigned AXIS_KEEP_WIDTH      = 64,
  parameter int unsigned AXIS_LAN_TDEST_WIDTH = 16,
  parameter int unsigned AXIS_LAN_TUSER_WIDTH = 16,
  localparam int unsigned GW                  = $clog2(NUM_REQ)
) (
  input  logic                                      i_clk,
  input  logic                                      i_ap_rst_n,
  input  logic [NUM_REQ-1:0]                        req_tvalid,
  output logic [NUM_REQ-1:0]                        req_tready,
  input  logic [NUM_REQ*AXIS_DATA_WIDTH-1:0]        req_tdata,
  input  logic [NUM_REQ*AXIS_KEEP_WIDTH-1:0]        req_tkeep,
  input  logic [NUM_REQ*AXIS_LAN_TDEST_WIDTH-1:0]   req_tid,
  input  logic [NUM_REQ*AXIS_LAN_TDEST_WIDTH-1:0]   req_tdest,
  input  logic [NUM_REQ*AXIS_LAN_TUSER_WIDTH-1:0]   req_tuser,
  input  logic [NUM_REQ-1:0]                        req_tlast,
  output logic                                      to_nb_LAN_tvalid,
  input  logic                                      to_nb_LAN_tready,
  output logic [AXIS_DATA_WIDTH-1:0]                to_nb_LAN_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]                to_nb_LAN_tkeep,
  output logic [AXIS_LAN_TDEST_WIDTH-1:0]           to_nb_LAN_tid,
  output logic [AXIS_LAN_TDEST_WIDTH-1:0]           to_nb_LAN_tdest,
  output logic [AXIS_LAN_TUSER_WIDTH-1:0]           to_nb_LAN_tuser,
  output logic                                      to_nb_LAN_tlast,
  output logic [GW-1:0]                             o_grant_id,
  output logic                                      o_busy
);

  typedef enum logic {STATE_IDLE, STATE_FORWARD} state_t;

  state_t                            state_q;
  logic [GW-1:0]                     grant_q;
  logic [GW-1:0]                     rr_ptr_q;
  logic                              out_valid_q;
  logic [AXIS_DATA_WIDTH-1:0]        out_tdata_q;
  logic [AXIS_KEEP_WIDTH-1:0]        out_tkeep_q;
  logic [AXIS_LAN_TDEST_WIDTH-1:0]   out_tid_q;
  logic [AXIS_LAN_TDEST_WIDTH-1:0]   out_tdest_q;
  logic [AXIS_LAN_TUSER_WIDTH-1:0]   out_tuser_q;
  logic                              out_tlast_q;

  logic [GW-1:0]                     winner_c;
  logic                              winner_vld_c;
  logic                              slot_free_c;
  logic                              accept_c;
  logic [31:0]                       gsel_c;
  logic [AXIS_DATA_WIDTH-1:0]        sel_tdata_c;
  logic [AXIS_KEEP_WIDTH-1:0]        sel_tkeep_c;
  logic [AXIS_LAN_TDEST_WIDTH-1:0]   sel_tid_c;
  logic [AXIS_LAN_TDEST_WIDTH-1:0]   sel_tdest_c;
  logic [AXIS_LAN_TUSER_WIDTH-1:0]   sel_tuser_c;
  logic                              sel_tlast_c;

  // Modulo-NUM_REQ increment by explicit compare, valid for non-power-of-2 NUM_REQ.
  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return GW'(sum);
  endfunction

  // First valid requester at or after the round-robin pointer.
  always_comb begin : arb_search
    logic [GW-1:0] idx;
    idx          = '0;
    winner_c     = '0;
    winner_vld_c = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = wrap_inc(rr_ptr_q, k);
      if (!winner_vld_c && req_tvalid[idx]) begin
        winner_c     = idx;
        winner_vld_c = 1'b1;
      end
    end
`ifdef RPN_LAN_ARB_ACK_PRIORITY_EN
    if (req_tvalid[0]) begin
      winner_c     = '0;
      winner_vld_c = 1'b1;
    end
`endif
  end

  assign gsel_c      = 32'(grant_q);
  assign sel_tdata_c = req_tdata[gsel_c*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
  assign sel_tkeep_c = req_tkeep[gsel_c*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
  assign sel_tid_c   = req_tid[gsel_c*AXIS_LAN_TDEST_WIDTH +: AXIS_LAN_TDEST_WIDTH];
  assign sel_tdest_c = req_tdest[gsel_c*AXIS_LAN_TDEST_WIDTH +: AXIS_LAN_TDEST_WIDTH];
  assign sel_tuser_c = req_tuser[gsel_c*AXIS_LAN_TUSER_WIDTH +: AXIS_LAN_TUSER_WIDTH];
  assign sel_tlast_c = req_tlast[grant_q];

  // The output slot can take a beat when empty or draining this cycle.
  assign slot_free_c = ~out_valid_q | to_nb_LAN_tready;
  assign accept_c    = (state_q == STATE_FORWARD) & req_tvalid[grant_q] & slot_free_c;

  always_comb begin
    req_tready = '0;
    if (state_q == STATE_FORWARD) req_tready[grant_q] = slot_free_c;
  end

  // FSM, round-robin pointer and output stage share one synchronous-reset register block.
  always_ff @(posedge i_clk) begin
    if (!i_ap_rst_n) begin
      state_q     <= STATE_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_tdata_q <= '0;
      out_tkeep_q <= '0;
      out_tid_q   <= '0;
      out_tdest_q <= '0;
      out_tuser_q <= '0;
      out_tlast_q <= 1'b0;
    end else begin
      case (state_q)
        STATE_IDLE: begin
          if (winner_vld_c) begin
            grant_q <= winner_c;
            state_q <= STATE_FORWARD;
          end
        end
        STATE_FORWARD: begin
          if (accept_c && sel_tlast_c) begin
            state_q <= STATE_IDLE;
`ifdef RPN_LAN_ARB_ACK_PRIORITY_EN
            if (grant_q != '0) rr_ptr_q <= wrap_inc(grant_q, 1);
`else
            rr_ptr_q <= wrap_inc(grant_q, 1);
`endif
          end
        end
        default: state_q <= STATE_IDLE;
      endcase

      // Load wins over drain, so a simultaneous load/drain is a pass-through.
      if (accept_c) begin
        out_valid_q <= 1'b1;
        out_tdata_q <= sel_tdata_c;
        out_tkeep_q <= sel_tkeep_c;
        out_tid_q   <= sel_tid_c;
        out_tdest_q <= sel_tdest_c;
        out_tuser_q <= sel_tuser_c;
        out_tlast_q <= sel_tlast_c;
      end else if (to_nb_LAN_tready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign to_nb_LAN_tvalid = out_valid_q;
  assign to_nb_LAN_tdata  = out_tdata_q;
  assign to_nb_LAN_tkeep  = out_tkeep_q;
  assign to_nb_LAN_tid    = out_tid_q;
  assign to_nb_LAN_tdest  = out_tdest_q;
  assign to_nb_LAN_tuser  = out_tuser_q;
  assign to_nb_LAN_tlast  = out_tlast_q;
  assign o_grant_id       = grant_q;
  assign o_busy           = (state_q == STATE_FORWARD);

endmodule

// File: tb/tb_rpn_lan_tx_arbiter.sv
// Directed bench for rpn_lan_tx_arbiter: requester queues feed the DUT, accepted output beats are logged and compared.
`timescale 1ns/1ps
module tb_rpn_lan_tx_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned KW = 4;
  localparam int unsigned TW = 16;
  localparam int unsigned UW = 16;
  localparam int unsigned GW = $clog2(NR);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ds_ready = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_tvalid;
  logic [NR-1:0]    req_tready;
  logic [NR*DW-1:0] req_tdata;
  logic [NR*KW-1:0] req_tkeep;
  logic [NR*TW-1:0] req_tid;
  logic [NR*TW-1:0] req_tdest;
  logic [NR*UW-1:0] req_tuser;
  logic [NR-1:0]    req_tlast;
  logic             to_nb_tvalid;
  logic [DW-1:0]    to_nb_tdata;
  logic [KW-1:0]    to_nb_tkeep;
  logic [TW-1:0]    to_nb_tid;
  logic [TW-1:0]    to_nb_tdest;
  logic [UW-1:0]    to_nb_tuser;
  logic             to_nb_tlast;
  logic [GW-1:0]    grant_id;
  logic             busy;

  rpn_lan_tx_arbiter #(
    .NUM_REQ(NR), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW),
    .AXIS_LAN_TDEST_WIDTH(TW), .AXIS_LAN_TUSER_WIDTH(UW)
  ) dut (
    .i_clk(clk), .i_ap_rst_n(rst_n),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .req_tkeep(req_tkeep), .req_tid(req_tid), .req_tdest(req_tdest),
    .req_tuser(req_tuser), .req_tlast(req_tlast),
    .to_nb_LAN_tvalid(to_nb_tvalid), .to_nb_LAN_tready(ds_ready),
    .to_nb_LAN_tdata(to_nb_tdata), .to_nb_LAN_tkeep(to_nb_tkeep),
    .to_nb_LAN_tid(to_nb_tid), .to_nb_LAN_tdest(to_nb_tdest),
    .to_nb_LAN_tuser(to_nb_tuser), .to_nb_LAN_tlast(to_nb_tlast),
    .o_grant_id(grant_id), .o_busy(busy)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t src_q[NR][$];
  beat_t out_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // user = {source index, beat index} so the output log identifies every beat.
  task automatic push_pkt(input int src, input int nbeats, input logic [DW-1:0] base);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.data = base + DW'(k);
      b.user = {8'(src), 8'(k)};
      b.last = (k == nbeats - 1);
      src_q[src].push_back(b);
    end
  endtask

  function automatic bit pending();
    bit p;
    p = to_nb_tvalid | busy;
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (pending() && cyc < 300);
    check("idle_timeout", 64'(cyc < 300), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_q.delete();
  endtask

  // Requester sources and output logger: sample handshakes before the edge, update after it.
  initial begin
    logic [NR-1:0] fire;
    beat_t ob;
    req_tvalid = '0; req_tdata = '0; req_tkeep = '0; req_tid = '0;
    req_tdest  = '0; req_tuser = '0; req_tlast = '0;
    forever begin
      @(negedge clk);
      #2;
      fire = req_tvalid & req_tready;
      if (to_nb_tvalid && ds_ready && rst_n) begin
        ob.data = to_nb_tdata; ob.user = to_nb_tuser; ob.last = to_nb_tlast;
        out_q.push_back(ob);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        req_tvalid[i] = (src_q[i].size() != 0);
        if (src_q[i].size() != 0) begin
          req_tdata[i*DW +: DW] = src_q[i][0].data;
          req_tuser[i*UW +: UW] = src_q[i][0].user;
          req_tlast[i]          = src_q[i][0].last;
          req_tkeep[i*KW +: KW] = '1;
          req_tid[i*TW +: TW]   = TW'(i);
          req_tdest[i*TW +: TW] = TW'(16'h00A0 + i);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_fair[6];
    int exp_lock[5];
    logic [DW-1:0] lock_data[5];
    int cyc;

    // Reset values and single-beat packet timing
    do_reset();
    check("rst_tvalid", 64'(to_nb_tvalid), 64'(0));
    check("rst_tdata",  64'(to_nb_tdata), 64'(0));
    check("rst_tready", 64'(req_tready), 64'(0));
    check("rst_grant",  64'(grant_id), 64'(0));
    check("rst_busy",   64'(busy), 64'(0));
    check("rst_rrptr",  64'(dut.rr_ptr_q), 64'(0));
    push_pkt(1, 1, 32'hA5);
    @(negedge clk);
    check("t1_idle_tready", 64'(req_tready), 64'(0));
    @(negedge clk);
    check("t1_tready", 64'(req_tready), 64'(3'b010));
    check("t1_busy1",  64'(busy), 64'(1));
    check("t1_grant",  64'(grant_id), 64'(1));
    @(negedge clk);
    check("t1_tvalid", 64'(to_nb_tvalid), 64'(1));
    check("t1_tdata",  64'(to_nb_tdata), 64'(32'hA5));
    check("t1_tlast",  64'(to_nb_tlast), 64'(1));
    check("t1_tid",    64'(to_nb_tid), 64'(1));
    check("t1_busy0",  64'(busy), 64'(0));
    check("t1_rrptr",  64'(dut.rr_ptr_q), 64'(2));
    wait_idle();

    // Fairness with every requester holding two single-beat packets
    do_reset();
`ifdef RPN_LAN_ARB_ACK_PRIORITY_EN
    exp_fair = '{0, 0, 1, 2, 1, 2};
`else
    exp_fair = '{0, 1, 2, 0, 1, 2};
`endif
    for (int i = 0; i < NR; i++) begin
      push_pkt(i, 1, 32'h2000 + 32'(i * 16));
      push_pkt(i, 1, 32'h2000 + 32'(i * 16 + 1));
    end
    wait_idle();
    check("t2_count", 64'(out_q.size()), 64'(6));
    for (int k = 0; k < 6 && k < out_q.size(); k++)
      check($sformatf("t2_src%0d", k), 64'(out_q[k].user[15:8]), 64'(exp_fair[k]));
    out_q.delete();

    // Packet lock: req0 arrives after req2's first beat is taken
    exp_lock  = '{2, 2, 2, 2, 0};
    lock_data = '{32'h3000, 32'h3001, 32'h3002, 32'h3003, 32'h3100};
    push_pkt(2, 4, 32'h3000);
    @(negedge clk);
    @(negedge clk);
    push_pkt(0, 1, 32'h3100);
    wait_idle();
    check("t3_count", 64'(out_q.size()), 64'(5));
    for (int k = 0; k < 5 && k < out_q.size(); k++) begin
      check($sformatf("t3_src%0d", k), 64'(out_q[k].user[15:8]), 64'(exp_lock[k]));
      check($sformatf("t3_data%0d", k), 64'(out_q[k].data), 64'(lock_data[k]));
    end
    out_q.delete();

    // Backpressure: downstream stalls 5 cycles with the first beat of 3 held
    ds_ready = 1'b0;
    push_pkt(1, 3, 32'h4000);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_tvalid%0d", k), 64'(to_nb_tvalid), 64'(1));
      check($sformatf("t4_tdata%0d", k), 64'(to_nb_tdata), 64'(32'h4000));
      check($sformatf("t4_tready%0d", k), 64'(req_tready), 64'(0));
      @(negedge clk);
    end
    ds_ready = 1'b1;
    wait_idle();
    check("t4_count", 64'(out_q.size()), 64'(3));
    for (int k = 0; k < 3 && k < out_q.size(); k++) begin
      check($sformatf("t4_data%0d", k), 64'(out_q[k].data), 64'(32'h4000 + k));
      check($sformatf("t4_last%0d", k), 64'(out_q[k].last), 64'(k == 2));
    end
    out_q.delete();

    // Reset for one cycle in the middle of a 4-beat packet
    push_pkt(0, 4, 32'h5000);
    cyc = 0;
    while (out_q.size() < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_wait", 64'(out_q.size() >= 2), 64'(1));
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    @(negedge clk);
    check("t5_tvalid", 64'(to_nb_tvalid), 64'(0));
    check("t5_tready", 64'(req_tready), 64'(0));
    check("t5_busy",   64'(busy), 64'(0));
    check("t5_rrptr",  64'(dut.rr_ptr_q), 64'(0));
    rst_n = 1'b1;
    out_q.delete();
    push_pkt(1, 2, 32'h5100);
    wait_idle();
    check("t5_count", 64'(out_q.size()), 64'(2));
    if (out_q.size() == 2) begin
      check("t5_data0", 64'(out_q[0].data), 64'(32'h5100));
      check("t5_data1", 64'(out_q[1].data), 64'(32'h5101));
      check("t5_last1", 64'(out_q[1].last), 64'(1));
    end
    out_q.delete();

    // Pointer at 2 with req0 and req2 both waiting in IDLE
    do_reset();
    push_pkt(1, 1, 32'h6000);
    wait_idle();
    check("t6_rrptr_pre", 64'(dut.rr_ptr_q), 64'(2));
    out_q.delete();
    push_pkt(0, 1, 32'h6100);
    push_pkt(2, 1, 32'h6200);
    wait_idle();
    check("t6_count", 64'(out_q.size()), 64'(2));
`ifdef RPN_LAN_ARB_ACK_PRIORITY_EN
    if (out_q.size() == 2) begin
      check("t6_first",  64'(out_q[0].user[15:8]), 64'(0));
      check("t6_second", 64'(out_q[1].user[15:8]), 64'(2));
    end
    check("t6_rrptr", 64'(dut.rr_ptr_q), 64'(0));
    check("t6_grant", 64'(grant_id), 64'(2));
`else
    if (out_q.size() == 2) begin
      check("t6_first",  64'(out_q[0].user[15:8]), 64'(2));
      check("t6_second", 64'(out_q[1].user[15:8]), 64'(0));
    end
    check("t6_rrptr", 64'(dut.rr_ptr_q), 64'(1));
    check("t6_grant", 64'(grant_id), 64'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
